// File: rtl/mw_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mw_pkg
//  Description : Shared definitions for the memory/writeback control stage:
//                RV opcodes, funct3 encodings, writeback-select and FSM state
//                types, and the default tohost CSR address.
//  Revision    : 1.0 - initial release
// ============================================================================
package mw_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_32  = 7'b0111011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Load/store size encodings (stores use only the first four)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // CSR write forms that can update tohost
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRWI = 3'b101;

    localparam logic [11:0] CSR_TOHOST_DEFAULT = 12'h51E;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } mw_state_t;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mw_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mw_stage_ctrl_if
//  Description : X-stage / data-memory / writeback bundle for mw_stage_ctrl.
//                master : X-stage and memory side (drives x_*, flush, dmem_*)
//                slave  : the MW control stage (drives masks, enables, data)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mw_stage_ctrl_if #(
    parameter int XLEN = 32
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    logic            x_valid;
    logic [6:0]      x_opcode;
    logic [2:0]      x_funct3;
    logic [11:0]     x_csr;
    logic [OFFW-1:0] x_addr_lo;
    logic            flush;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    logic [NB-1:0]   w_mask;
    logic            re;
    logic [1:0]      wb_sel;
    logic            rwe;
    logic            csr_we;
    logic [XLEN-1:0] ld_data;
    logic            stall;
    logic            misalign;

    modport master (
        output x_valid, x_opcode, x_funct3, x_csr, x_addr_lo,
        output flush, dmem_ready, dmem_rdata,
        input  w_mask, re, wb_sel, rwe, csr_we, ld_data, stall, misalign
    );

    modport slave (
        input  x_valid, x_opcode, x_funct3, x_csr, x_addr_lo,
        input  flush, dmem_ready, dmem_rdata,
        output w_mask, re, wb_sel, rwe, csr_we, ld_data, stall, misalign
    );

endinterface
`default_nettype wire

// File: rtl/mw_stage_ctrl_load_extract.sv
`default_nettype none
// ============================================================================
//  Module      : mw_load_extract
//  Description : Aligns the raw memory word to the addressed lane and sign-
//                or zero-extends it according to the load funct3.
//  Ports       : funct3  - load size/sign encoding
//                addr_lo - byte offset of the access within the word
//                rdata   - raw memory read word
//                data    - aligned, extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module mw_load_extract
    import mw_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [2:0]                 funct3,
    input  wire logic [$clog2(XLEN/8)-1:0]  addr_lo,
    input  wire logic [XLEN-1:0]            rdata,
    output logic      [XLEN-1:0]            data
);
    localparam int OFFW = $clog2(XLEN / 8);

    logic [OFFW-1:0] w_off;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_word_s;
    logic [XLEN-1:0] w_word_z;

    // Offset is rounded down to the natural alignment of the access size
    always_comb begin
        w_off = '0;
        case (funct3[1:0])
            2'b00:   w_off = addr_lo;
            2'b01:   w_off = addr_lo & ~OFFW'(1);
            2'b10:   w_off = addr_lo & ~OFFW'(3);
            default: w_off = '0;
        endcase
    end

    assign w_shifted = rdata >> {w_off, 3'b000};

    // Word extension only does anything on a 64-bit datapath
    generate
        if (XLEN == 64) begin : g_word_64
            assign w_word_s = {{32{w_shifted[31]}}, w_shifted[31:0]};
            assign w_word_z = {32'b0, w_shifted[31:0]};
        end else begin : g_word_32
            assign w_word_s = w_shifted;
            assign w_word_z = w_shifted;
        end
    endgenerate

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            F3_H:    data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    data = w_word_s;
            F3_D:    data = w_shifted;
            F3_BU:   data = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            F3_HU:   data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            F3_WU:   data = w_word_z;
            default: data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mw_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mw_stage_ctrl
//  Description : Memory/writeback control stage. Registers X-stage control
//                into the MW pipeline register, issues byte write masks and
//                read enable, selects the writeback source, aligns/extends
//                load data and stalls upstream while memory is not ready.
//  Ports       : clk, reset (async, active-high)
//                bus (mw_stage_ctrl_if.slave): X-stage inputs, flush, data
//                memory handshake, w_mask/re, wb_sel/rwe/csr_we, ld_data,
//                stall, misalign
//  Config      : MW_MISALIGN_TRAP_EN - flag misaligned X-stage accesses and
//                suppress their w_mask/re; when undefined misalign is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mw_stage_ctrl
    import mw_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter logic [11:0] CSR_TOHOST = CSR_TOHOST_DEFAULT
) (
    input wire logic        clk,
    input wire logic        reset,
    mw_stage_ctrl_if.slave  bus
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    logic            r_mw_valid;
    logic [6:0]      r_mw_opcode;
    logic [2:0]      r_mw_funct3;
    logic [11:0]     r_mw_csr;
    logic [OFFW-1:0] r_mw_addr_lo;
    mw_state_t       r_state;

    mw_state_t       w_state_nxt;
    logic            w_stall;
    logic            w_issue;
    logic            w_misalign;
    logic            w_x_load;
    logic            w_x_store;
    logic [NB-1:0]   w_base;
    logic [OFFW-1:0] w_off;
    logic            w_rwe_op;
    wb_sel_t         w_wb_sel;
    logic [XLEN-1:0] w_ld_raw;

    // ---------------- MW register and state ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_mw_valid   <= 1'b0;
            r_mw_opcode  <= '0;
            r_mw_funct3  <= '0;
            r_mw_csr     <= '0;
            r_mw_addr_lo <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.flush) begin
                r_mw_valid <= 1'b0;
            end else if (!w_stall) begin
                r_mw_valid   <= bus.x_valid;
                r_mw_opcode  <= bus.x_opcode;
                r_mw_funct3  <= bus.x_funct3;
                r_mw_csr     <= bus.x_csr;
                r_mw_addr_lo <= bus.x_addr_lo;
            end
        end
    end

    // Memory wait machine; a flush abandons the wait because the access is dead
    always_comb begin
        w_stall     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                w_stall = r_mw_valid & is_mem_op(r_mw_opcode) & ~bus.dmem_ready;
                if (w_stall && !bus.flush) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_stall = ~bus.dmem_ready;
                if (bus.dmem_ready || bus.flush) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign bus.stall = w_stall;

    // ---------------- X-stage request side ----------------
    assign w_x_load  = (bus.x_opcode == OPC_LOAD);
    assign w_x_store = (bus.x_opcode == OPC_STORE);

    // Lane mask before shifting; SD only exists on a 64-bit datapath
    always_comb begin
        w_base = '0;
        w_off  = '0;
        case (bus.x_funct3)
            F3_B: begin w_base = NB'(1);  w_off = bus.x_addr_lo;               end
            F3_H: begin w_base = NB'(3);  w_off = bus.x_addr_lo & ~OFFW'(1);   end
            F3_W: begin w_base = NB'(15); w_off = bus.x_addr_lo & ~OFFW'(3);   end
            F3_D: begin w_base = (XLEN == 64) ? '1 : '0; w_off = '0;          end
            default: begin w_base = '0; w_off = '0; end
        endcase
    end

`ifdef MW_MISALIGN_TRAP_EN
    logic [OFFW-1:0] w_align_mask;
    assign w_align_mask = OFFW'((4'd1 << bus.x_funct3[1:0]) - 4'd1);
    assign w_misalign   = bus.x_valid & (w_x_load | w_x_store) &
                          ((bus.x_addr_lo & w_align_mask) != '0);
`else
    assign w_misalign   = 1'b0;
`endif

    assign w_issue      = bus.x_valid & ~w_stall & ~bus.flush & ~w_misalign;
    assign bus.w_mask   = (w_issue && w_x_store) ? (w_base << w_off) : '0;
    assign bus.re       = w_issue & w_x_load;
    assign bus.misalign = w_misalign;

    // ---------------- Writeback side ----------------
    always_comb begin
        w_rwe_op = 1'b0;
        case (r_mw_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OP, OPC_OP_IMM: w_rwe_op = 1'b1;
            OPC_OP_32:                    w_rwe_op = (XLEN == 64);
            OPC_SYSTEM:                   w_rwe_op = (r_mw_funct3 != 3'b000);
            default:                      w_rwe_op = 1'b0;
        endcase
    end

    always_comb begin
        w_wb_sel = WB_ALU;
        if (r_mw_opcode == OPC_LOAD)
            w_wb_sel = WB_MEM;
        else if (r_mw_opcode == OPC_JAL || r_mw_opcode == OPC_JALR)
            w_wb_sel = WB_PC4;
    end

    assign bus.wb_sel = w_wb_sel;
    assign bus.rwe    = r_mw_valid & ~w_stall & w_rwe_op;
    assign bus.csr_we = r_mw_valid & ~w_stall & (r_mw_opcode == OPC_SYSTEM) &
                        ((r_mw_funct3 == F3_CSRRW) || (r_mw_funct3 == F3_CSRRWI)) &
                        (r_mw_csr == CSR_TOHOST);

    mw_load_extract #(
        .XLEN (XLEN)
    ) u_load_extract (
        .funct3  (r_mw_funct3),
        .addr_lo (r_mw_addr_lo),
        .rdata   (bus.dmem_rdata),
        .data    (w_ld_raw)
    );

    // Only a live load presents data, so the idle/reset value is zero
    assign bus.ld_data = (r_mw_valid && r_mw_opcode == OPC_LOAD) ? w_ld_raw : '0;

endmodule
`default_nettype wire

// File: tb/tb_mw_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mw_stage_ctrl
//  Description : Self-checking bench for mw_stage_ctrl (XLEN=32): directed
//                scenarios plus randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mw_stage_ctrl;
    import mw_pkg::*;

    localparam int XLEN = 32;
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mw_stage_ctrl_if #(.XLEN(XLEN)) bus();

    mw_stage_ctrl #(
        .XLEN       (XLEN),
        .CSR_TOHOST (12'h51E)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [11:0] csr;
        int          a;
    } mw_t;

    // ---------------- stimulus helpers ----------------
    task automatic set_x(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [11:0] csr, input int a);
        bus.x_valid   = v;
        bus.x_opcode  = op;
        bus.x_funct3  = f3;
        bus.x_csr     = csr;
        bus.x_addr_lo = OFFW'(a);
    endtask

    task automatic idle_x();
        set_x(1'b0, 7'd0, 3'd0, 12'd0, 0);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [NB-1:0] exp_mask(input logic [2:0] f3, input int a);
        logic [NB-1:0] m;
        int n, start;
        m = '0;
        if (f3 > 3'd3) return m;
        n = 1 << f3[1:0];
        if (n > NB) return m;
        start = a - (a % n);
        for (int b = 0; b < NB; b++)
            if (b >= start && b < start + n) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic exp_mis(input logic v, input logic [6:0] op,
                                     input logic [2:0] f3, input int a);
`ifdef MW_MISALIGN_TRAP_EN
        return v && (op == OPC_LOAD || op == OPC_STORE) && ((a % (1 << f3[1:0])) != 0);
`else
        return 1'b0 & v & op[0] & f3[0] & (a != 0);
`endif
    endfunction

    function automatic logic [XLEN-1:0] exp_ld(input logic [2:0] f3, input int a,
                                              input logic [XLEN-1:0] rd);
        int n, start;
        logic [63:0] val, keep;
        n     = 1 << f3[1:0];
        start = a - (a % n);
        val   = 64'(rd) >> (8 * start);
        if (8 * n < XLEN) begin
            keep = (64'd1 << (8 * n)) - 64'd1;
            val  = val & keep;
            if (!f3[2] && val[8*n-1]) val = val | ~keep;
        end
        return val[XLEN-1:0];
    endfunction

    function automatic logic exp_rwe_op(input logic [6:0] op, input logic [2:0] f3);
        return (op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL) ||
               (op == OPC_JALR) || (op == OPC_LOAD) || (op == OPC_OP) ||
               (op == OPC_OP_IMM) || (op == OPC_OP_32 && XLEN == 64) ||
               (op == OPC_SYSTEM && f3 != 3'b000);
    endfunction

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 11))
            0:  return OPC_LOAD;
            1:  return OPC_STORE;
            2:  return OPC_OP;
            3:  return OPC_OP_IMM;
            4:  return OPC_LUI;
            5:  return OPC_AUIPC;
            6:  return OPC_JAL;
            7:  return OPC_JALR;
            8:  return OPC_SYSTEM;
            9:  return OPC_OP_32;
            10: return OPC_LOAD;
            default: return OPC_STORE;
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_x();
        bus.flush = 1'b0; bus.dmem_ready = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall actual=%b required=0", bus.stall); end
        checks++; if (bus.rwe !== 1'b0) begin failures++; $display("FAIL reset_rwe actual=%b required=0", bus.rwe); end
        checks++; if (bus.csr_we !== 1'b0) begin failures++; $display("FAIL reset_csr_we actual=%b required=0", bus.csr_we); end
        checks++; if (bus.w_mask !== 4'h0) begin failures++; $display("FAIL reset_w_mask actual=%h required=0", bus.w_mask); end
        checks++; if (bus.wb_sel !== 2'd1) begin failures++; $display("FAIL reset_wb_sel actual=%0d required=1", bus.wb_sel); end
        checks++; if (bus.ld_data !== 32'h0) begin failures++; $display("FAIL reset_ld_data actual=%h required=0", bus.ld_data); end
        checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign actual=%b required=0", bus.misalign); end
        reset = 1'b0;
    endtask

    task automatic test_store_masks();
        logic [2:0] f3s [5];
        int         as  [5];
        logic [3:0] ex  [5];
        logic       fl  [5];
        f3s = '{F3_B, F3_H, F3_W, F3_D, F3_B};
        as  = '{3, 2, 0, 0, 1};
        ex  = '{4'b1000, 4'b1100, 4'b1111, 4'b0000, 4'b0000};
        fl  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_x(1'b1, OPC_STORE, f3s[i], 12'd0, as[i]);
            bus.flush = fl[i];
            #1;
            checks++;
            if (bus.w_mask !== ex[i]) begin
                failures++;
                $display("FAIL store_mask[%0d] actual=%b required=%b", i, bus.w_mask, ex[i]);
            end
        end
`ifdef MW_MISALIGN_TRAP_EN
        @(negedge clk);
        set_x(1'b1, OPC_STORE, F3_W, 12'd0, 1);
        bus.flush = 1'b0;
        #1;
        checks++; if (bus.misalign !== 1'b1) begin failures++; $display("FAIL sw_misalign actual=%b required=1", bus.misalign); end
        checks++; if (bus.w_mask !== 4'h0) begin failures++; $display("FAIL sw_misalign_mask actual=%b required=0000", bus.w_mask); end
`endif
        @(negedge clk);
        idle_x(); bus.flush = 1'b0;
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s [2];
        logic [31:0] ex  [2];
        f3s = '{F3_B, F3_BU};
        ex  = '{32'hFFFFFF80, 32'h00000080};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_x(1'b1, OPC_LOAD, f3s[i], 12'd0, 1);
            bus.dmem_ready = 1'b1; bus.dmem_rdata = 32'h00008000;
            #1;
            checks++; if (bus.re !== 1'b1) begin failures++; $display("FAIL load_re[%0d] actual=%b required=1", i, bus.re); end
            @(negedge clk);
            idle_x();
            #1;
            checks++;
            if (bus.ld_data !== ex[i]) begin
                failures++;
                $display("FAIL load_ext[%0d] actual=%h required=%h", i, bus.ld_data, ex[i]);
            end
            checks++; if (bus.wb_sel !== 2'd0) begin failures++; $display("FAIL load_wb_sel[%0d] actual=%0d required=0", i, bus.wb_sel); end
        end
    endtask

    task automatic test_mem_wait();
        @(negedge clk);
        set_x(1'b1, OPC_LOAD, F3_W, 12'd0, 0);
        bus.dmem_ready = 1'b0; bus.dmem_rdata = 32'h12345678;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_x();
            bus.dmem_ready = (i == 3);
            #1;
            checks++;
            if (bus.stall !== (i < 3)) begin
                failures++;
                $display("FAIL wait_stall[%0d] actual=%b required=%b", i, bus.stall, (i < 3));
            end
            checks++;
            if (bus.rwe !== (i == 3)) begin
                failures++;
                $display("FAIL wait_rwe[%0d] actual=%b required=%b", i, bus.rwe, (i == 3));
            end
            if (i == 3) begin
                checks++; if (bus.wb_sel !== 2'd0) begin failures++; $display("FAIL wait_wb_sel actual=%0d required=0", bus.wb_sel); end
                checks++; if (bus.ld_data !== 32'h12345678) begin failures++; $display("FAIL wait_ld_data actual=%h required=12345678", bus.ld_data); end
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.dmem_ready = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL wait_done_stall actual=%b required=0", bus.stall); end
        bus.dmem_ready = 1'b1;
    endtask

    task automatic test_csr();
        logic [11:0] csrs [2];
        logic        ex   [2];
        csrs = '{12'h51E, 12'h51F};
        ex   = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_x(1'b1, OPC_SYSTEM, F3_CSRRW, csrs[i], 0);
            #1;
            checks++; if (bus.csr_we !== 1'b0) begin failures++; $display("FAIL csr_early[%0d] actual=%b required=0", i, bus.csr_we); end
            @(negedge clk);
            idle_x();
            #1;
            checks++; if (bus.csr_we !== ex[i]) begin failures++; $display("FAIL csr_we[%0d] actual=%b required=%b", i, bus.csr_we, ex[i]); end
            checks++; if (bus.rwe !== 1'b1) begin failures++; $display("FAIL csr_rwe[%0d] actual=%b required=1", i, bus.rwe); end
        end
    endtask

    task automatic enter_wait();
        @(negedge clk);
        set_x(1'b1, OPC_LOAD, F3_W, 12'd0, 0);
        bus.dmem_ready = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        idle_x();
        @(negedge clk);
    endtask

    task automatic test_flush_wait();
        enter_wait();
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL flush_wait_stall actual=%b required=1", bus.stall); end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL flush_after_stall actual=%b required=0", bus.stall); end
        checks++; if (bus.rwe !== 1'b0) begin failures++; $display("FAIL flush_after_rwe actual=%b required=0", bus.rwe); end
        bus.dmem_ready = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        enter_wait();
        bus.dmem_rdata = 32'hCAFEF00D;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_wait_stall actual=%b required=0", bus.stall); end
        checks++; if (bus.rwe !== 1'b0) begin failures++; $display("FAIL rst_wait_rwe actual=%b required=0", bus.rwe); end
        checks++; if (bus.wb_sel !== 2'd1) begin failures++; $display("FAIL rst_wait_wb_sel actual=%0d required=1", bus.wb_sel); end
        checks++; if (bus.ld_data !== 32'h0) begin failures++; $display("FAIL rst_wait_ld_data actual=%h required=0", bus.ld_data); end
        checks++; if (bus.w_mask !== 4'h0) begin failures++; $display("FAIL rst_wait_w_mask actual=%h required=0", bus.w_mask); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_wait_run actual=%b required=0", bus.stall); end
        bus.dmem_ready = 1'b1;
    endtask

    task automatic test_random(input int n);
        mw_t           m;
        logic          e_stall, e_mis, e_issue, e_rwe, e_csr;
        logic [NB-1:0] e_mask;
        logic [1:0]    e_wb;
        logic [XLEN-1:0] e_ld;
        logic [6:0]    op;
        logic [2:0]    f3;
        logic [11:0]   csr;
        int            a;
        logic          v;
        int            fail_start;
        fail_start = failures;
        @(negedge clk);
        idle_x(); bus.flush = 1'b0; bus.dmem_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m = '{v: 1'b0, op: 7'd0, f3: 3'd0, csr: 12'd0, a: 0};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            op = pick_op();
            f3 = 3'($urandom_range(0, 7));
            if (op == OPC_LOAD && f3[1:0] == 2'b11) f3 = f3 & 3'b110;
            case ($urandom_range(0, 3))
                0: csr = 12'h51E;
                1: csr = 12'h51F;
                default: csr = 12'($urandom);
            endcase
            a = $urandom_range(0, NB - 1);
            v = ($urandom_range(0, 3) != 0);
            set_x(v, op, f3, csr, a);
            bus.flush      = ($urandom_range(0, 7) == 0);
            bus.dmem_ready = ($urandom_range(0, 2) != 0);
            bus.dmem_rdata = $urandom;
            #1;
            e_stall = m.v && (m.op == OPC_LOAD || m.op == OPC_STORE) && !bus.dmem_ready;
            e_mis   = exp_mis(v, op, f3, a);
            e_issue = v && !e_stall && !bus.flush && !e_mis;
            e_mask  = (e_issue && op == OPC_STORE) ? exp_mask(f3, a) : '0;
            e_rwe   = m.v && !e_stall && exp_rwe_op(m.op, m.f3);
            e_csr   = m.v && !e_stall && m.op == OPC_SYSTEM &&
                      (m.f3 == 3'b001 || m.f3 == 3'b101) && m.csr == 12'h51E;
            e_wb    = (m.op == OPC_LOAD) ? 2'd0 :
                      (m.op == OPC_JAL || m.op == OPC_JALR) ? 2'd2 : 2'd1;
            e_ld    = (m.v && m.op == OPC_LOAD) ? exp_ld(m.f3, m.a, bus.dmem_rdata) : '0;
            checks++; if (bus.stall !== e_stall) begin failures++; $display("FAIL rnd_stall[%0d] actual=%b required=%b", i, bus.stall, e_stall); end
            checks++; if (bus.w_mask !== e_mask) begin failures++; $display("FAIL rnd_w_mask[%0d] actual=%b required=%b", i, bus.w_mask, e_mask); end
            checks++; if (bus.re !== (e_issue && op == OPC_LOAD)) begin failures++; $display("FAIL rnd_re[%0d] actual=%b required=%b", i, bus.re, (e_issue && op == OPC_LOAD)); end
            checks++; if (bus.rwe !== e_rwe) begin failures++; $display("FAIL rnd_rwe[%0d] actual=%b required=%b", i, bus.rwe, e_rwe); end
            checks++; if (bus.csr_we !== e_csr) begin failures++; $display("FAIL rnd_csr_we[%0d] actual=%b required=%b", i, bus.csr_we, e_csr); end
            checks++; if (bus.wb_sel !== e_wb) begin failures++; $display("FAIL rnd_wb_sel[%0d] actual=%0d required=%0d", i, bus.wb_sel, e_wb); end
            checks++; if (bus.ld_data !== e_ld) begin failures++; $display("FAIL rnd_ld_data[%0d] actual=%h required=%h", i, bus.ld_data, e_ld); end
            checks++; if (bus.misalign !== e_mis) begin failures++; $display("FAIL rnd_misalign[%0d] actual=%b required=%b", i, bus.misalign, e_mis); end
            @(posedge clk);
            if (bus.flush) m.v = 1'b0;
            else if (!e_stall) m = '{v: v, op: op, f3: f3, csr: csr, a: a};
            if (failures - fail_start > 20) break;
        end
        @(negedge clk);
        idle_x(); bus.flush = 1'b0; bus.dmem_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_store_masks();
        test_load_extend();
        test_mem_wait();
        test_csr();
        test_flush_wait();
        test_reset_mid_wait();
        test_random(400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mw_stage_ctrl.md
# mw_stage_ctrl

Parametrised memory/writeback control stage for the three-stage RISC-V pipeline, superseding the purely combinational MW decoder. Registers X-stage control into an MW pipeline register, issues byte write masks and read enables for `XLEN` of 32 or 64, and aligns/extends returned load data. It also holds the pipeline through a two-state memory-wait machine when the data memory is not ready. It sits between the execute stage and the register file/CSR writeback.

## Interface
- `XLEN`, 32: datapath width; 32 or 64 only.
- `CSR_TOHOST`, 12'h51E: the only CSR address that raises `csr_we`.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-high reset.
- `x_valid`  in  1  X-stage instruction valid.
- `x_opcode`  in  7  X-stage opcode.
- `x_funct3`  in  3  X-stage funct3.
- `x_csr`  in  12  X-stage CSR address.
- `x_addr_lo`  in  log2(XLEN/8)  low bits of the effective address.
- `flush`  in  1  kills the instruction entering MW.
- `dmem_ready`  in  1  data memory has completed the MW-stage access.
- `dmem_rdata`  in  XLEN  raw memory read word.
- `w_mask`  out  XLEN/8  byte write enables to data memory.
- `re`  out  1  data memory read enable.
- `wb_sel`  out  2  0 = memory, 1 = ALU, 2 = PC+4.
- `rwe`  out  1  register-file write enable.
- `csr_we`  out  1  tohost CSR write enable.
- `ld_data`  out  XLEN  aligned, sign- or zero-extended load result.
- `stall`  out  1  holds the upstream stages.
- `misalign`  out  1  misaligned access flag; present only when the macro is defined, otherwise tied 0.

## Operation
- MW register fields: `mw_valid`, opcode, funct3, csr, addr_lo.
- Update priority each clock: reset > flush (`mw_valid` <= 0) > stall (hold) > advance (load the X-stage fields).
- `w_mask` and `re` are combinational from the X-stage inputs. Both are gated by `x_valid & ~stall & ~flush`.
- Store `w_mask` by funct3 (all masks shifted by byte offset):
  - SB: 1 byte at `addr_lo`.
  - SH: 2 bytes at `addr_lo` with bit 0 cleared.
  - SW: 4 bytes at the word offset.
  - SD (`XLEN`=64 only): all 8 bytes.
- Store masks with `XLEN`=32: SD encoding yields a mask of 0.
- `re`: asserted for LOAD opcodes only.
- `wb_sel` (from MW fields): LOAD -> 0; JAL/JALR -> 2; everything else -> 1.
- `rwe`: `mw_valid & ~stall` and opcode is LUI, AUIPC, JAL, JALR, LOAD, OP, OP-IMM, OP-32 (`XLEN`=64) or SYSTEM CSR.
- `csr_we`: `mw_valid & ~stall`, opcode SYSTEM, funct3 001 or 101, and csr == `CSR_TOHOST`.
- `ld_data`: `dmem_rdata` shifted right by 8×`addr_lo` (byte offset taken per access size), then extended:
  - LB/LH/LW: sign-extended.
  - LBU/LHU/LWU: zero-extended.
  - LD: passed through.
- State machine:
  - RUN: `stall` = `mw_valid` & (LOAD or STORE) & ~`dmem_ready`; when `stall` = 1, go to WAIT.
  - WAIT: `stall` = ~`dmem_ready`; `dmem_ready` -> RUN.
  - WAIT with `flush`: return to RUN and clear `mw_valid`. A store already issued is not retracted.

## Timing
- Reset: all MW fields 0, state RUN; `stall`, `rwe`, `csr_we`, `misalign` and `w_mask` all 0; `wb_sel` 1; `ld_data` 0.
- `w_mask`/`re`: zero-cycle latency from the X-stage inputs.
- `wb_sel`/`rwe`/`csr_we`: valid one cycle after X-stage capture.
- `ld_data`: valid in the cycle `dmem_ready` is high.
- `dmem_ready` high in the first MW cycle means no stall and no WAIT entry.
- `flush` and `stall` together: flush wins.
- Reset asserted mid-WAIT: immediate return to RUN with all outputs at their reset values.

## Configuration
- `MW_MISALIGN_TRAP_EN` defined:
  - `misalign` is driven combinationally for the X-stage access: LH/LHU/SH at an odd address, or word/double access off its natural alignment.
  - A flagged access forces `w_mask` = 0 and `re` = 0.
- `MW_MISALIGN_TRAP_EN` undefined: `misalign` is tied 0, and mask bits shifted beyond the lane are dropped.

## Structure
- Package `mw_pkg`: opcode localparams, funct3 constants, `wb_sel_t` (MEM/ALU/PC4), `mw_state_t` (RUN/WAIT), default `CSR_TOHOST`.
- Sub-module `mw_load_extract`: the combinational `ld_data` shifter/extender, parametrised by `XLEN`.

## Test plan
- `XLEN`=32, SB, addr_lo=2'b11, x_valid=1 -> `w_mask`=4'b1000; SH at 2'b10 -> 4'b1100; SW -> 4'b1111.
- LB of 0x80 in byte 1 (rdata=0x00008000), addr_lo=1 -> `ld_data`=0xFFFFFF80; LBU of the same -> 0x00000080.
- Load with `dmem_ready` low for 3 cycles -> `stall`=1 for exactly 3 cycles and `rwe`=0; on the 4th cycle `rwe`=1 and `wb_sel`=0.
- CSRRW to 0x51E -> `csr_we`=1 one cycle later; CSRRW to 0x51F -> `csr_we`=0, `rwe`=1.
- Flush while in WAIT -> next cycle state RUN, `stall`=0, `rwe`=0; reset mid-WAIT -> all outputs at reset values.
- With `MW_MISALIGN_TRAP_EN`: SW at addr_lo=2'b01 -> `misalign`=1, `w_mask`=0; `XLEN`=64 SD at 3'b000 -> `w_mask`=8'hFF.
